// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb
//   Shares the single-port, synchronous-read PPU VRAM controller between two
//   requesters. The render fetch engine has high priority and may request on
//   every cycle. The CPU register path has low priority and holds at most one
//   outstanding operation.
//   Each cycle at most one access is issued. Read data is routed back to the
//   requester that issued it, in grant order. A saturating-style starvation
//   counter guarantees that a pending CPU op is eventually granted.
//
// Ports
//   clk, rst                          clock; asynchronous active-high reset
//   ren_req/ren_addr -> ren_ack       render request (level), combinational grant
//   ren_rd_valid/ren_rd_data          render read return (pulse / held data)
//   cpu_req/cpu_wr/cpu_addr/cpu_din   CPU op start pulse and its operands
//   cpu_busy                          CPU op pending (new requests ignored)
//   cpu_rd_valid/cpu_rd_data          CPU read return (pulse / held data)
//   mc_wr/mc_addr/mc_din              registered memory controller command
//   mc_dout                           memory read data, one cycle after mc_addr
module ppu_vram_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic        ren_ack,
  output logic        ren_rd_valid,
  output logic [7:0]  ren_rd_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_busy,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data,
  output logic        mc_wr,
  output logic [13:0] mc_addr,
  output logic [7:0]  mc_din,
  input  logic [7:0]  mc_dout
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {IDLE, PEND} state_e;

  state_e      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        op_wr_q;
  logic [13:0] op_addr_q;
  logic [7:0]  op_din_q;

  logic        cpu_grant;
  logic        ren_grant;

  logic        mc_wr_q;
  logic [13:0] mc_addr_q;
  logic [7:0]  mc_din_q;

  // Read tag pipe: stage 1 covers the cycle the address sits on mc_addr,
  // stage 2 the cycle mc_dout is valid. src=1 marks a CPU read.
  logic        t1_vld_q, t1_src_q;
  logic        t2_vld_q, t2_src_q;

  logic        ren_rd_valid_q, cpu_rd_valid_q;
  logic [7:0]  ren_rd_data_q, cpu_rd_data_q;

  // Arbitration and CPU op state. The op captured in IDLE only becomes
  // eligible once the state register reads PEND, so it can never win in its
  // capture cycle.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    cpu_grant = 1'b0;
    ren_grant = 1'b0;
    case (state_q)
      IDLE: begin
        ren_grant = ren_req;
        if (cpu_req) state_d = PEND;
      end
      PEND: begin
        cpu_grant = !ren_req || (starve_q == LIMIT);
        ren_grant = ren_req && !cpu_grant;
        if (cpu_grant) begin
          state_d  = IDLE;
          starve_d = 8'd0;
        end else if (ren_req) begin
          starve_d = starve_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      starve_q       <= 8'd0;
      op_wr_q        <= 1'b0;
      op_addr_q      <= 14'd0;
      op_din_q       <= 8'd0;
      mc_wr_q        <= 1'b0;
      mc_addr_q      <= 14'd0;
      mc_din_q       <= 8'd0;
      t1_vld_q       <= 1'b0;
      t1_src_q       <= 1'b0;
      t2_vld_q       <= 1'b0;
      t2_src_q       <= 1'b0;
      ren_rd_valid_q <= 1'b0;
      cpu_rd_valid_q <= 1'b0;
      ren_rd_data_q  <= 8'd0;
      cpu_rd_data_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;

      if (state_q == IDLE && cpu_req) begin
        op_wr_q   <= cpu_wr;
        op_addr_q <= cpu_addr;
        op_din_q  <= cpu_din;
      end

      // Issue: write strobe lasts exactly one cycle; address/data hold when idle.
      mc_wr_q <= cpu_grant && op_wr_q;
      if (cpu_grant) begin
        mc_addr_q <= op_addr_q;
        mc_din_q  <= op_din_q;
      end else if (ren_grant) begin
        mc_addr_q <= ren_addr;
      end

      t1_vld_q <= ren_grant || (cpu_grant && !op_wr_q);
      t1_src_q <= cpu_grant;
      t2_vld_q <= t1_vld_q;
      t2_src_q <= t1_src_q;

      ren_rd_valid_q <= t2_vld_q && !t2_src_q;
      cpu_rd_valid_q <= t2_vld_q && t2_src_q;
      if (t2_vld_q && !t2_src_q) ren_rd_data_q <= mc_dout;
      if (t2_vld_q && t2_src_q)  cpu_rd_data_q <= mc_dout;
    end
  end

  assign ren_ack      = ren_grant;
  assign cpu_busy     = (state_q == PEND);
  assign mc_wr        = mc_wr_q;
  assign mc_addr      = mc_addr_q;
  assign mc_din       = mc_din_q;
  assign ren_rd_valid = ren_rd_valid_q;
  assign ren_rd_data  = ren_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign cpu_rd_data  = cpu_rd_data_q;

endmodule
